alineador_coma: RTL and testbench

Serial-to-word aligner sitting directly downstream of the serial link, in place of a free-running deserializer. It consumes the 1-bit stream produced by the parallel-to-serial emitter and hunts for the K28.5 comma in either disparity. After a configurable number of commas appear on the same 10-bit boundary, it locks. Once locked, it emits aligned 10-bit symbols with a valid strobe to the 8b/10b decode stage.

---
 rtl/alineador_coma_pkg.sv | 33 +++
 rtl/detector_coma.sv | 49 ++++
 rtl/alineador_coma.sv | 214 +++++++++++++++++++++
 tb/tb_alineador_coma.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alineador_coma_pkg.sv
// -----------------------------------------------------------------------------
// alineador_coma_pkg
//
// Shared definitions for the comma aligner:
//   - K28.5 comma patterns in both running disparities (bit 9 = first on wire)
//   - aligner FSM state encoding
//   - symbol-length / phase constants
//   - es_k285(): helper that matches a 10-bit window against either comma
// -----------------------------------------------------------------------------
package alineador_coma_pkg;

   // Length of one 10b symbol and the phase value that marks its last bit.
   localparam int unsigned LARGO_SIMBOLO = 10;
   localparam logic [3:0]  FASE_ULTIMA   = 4'(LARGO_SIMBOLO - 1);

   // K28.5 in negative and positive running disparity.
   localparam logic [9:0] COMMA_N = 10'b0011111010;
   localparam logic [9:0] COMMA_P = 10'b1100000101;

   // Aligner state. The encodings are fixed so that they match the values
   // other blocks of the link use when they observe this state.
   typedef enum logic [1:0] {
      BUSCAR       = 2'd0,  // hunting for any comma
      VERIFICAR    = 2'd1,  // candidate boundary found, counting commas on it
      SINCRONIZADO = 2'd2   // locked, emitting aligned symbols
   } estado_e;

   // True when the 10-bit window is a K28.5 of either disparity.
   function automatic logic es_k285(input logic [9:0] ventana);
      return (ventana == COMMA_N) || (ventana == COMMA_P);
   endfunction

endpackage : alineador_coma_pkg

// File: rtl/detector_coma.sv
// -----------------------------------------------------------------------------
// detector_coma
//
// Serial front end of the comma aligner. Keeps the last nine received bits and
// presents, every cycle, the 10-bit window formed by those nine bits plus the
// bit currently on the input, together with a flag telling whether that window
// is a K28.5 comma. The window is what the aligner latches as a symbol, so the
// symbol whose last bit is on `entrada` at edge t is available at that edge
// with no extra register stage.
//
// Ports:
//   clk      in   bit clock, one serial bit per rising edge
//   reset_L  in   asynchronous active-low reset (clears the shift register)
//   entrada  in   serial data, earliest bit of a symbol first
//   w        out  [9:0] current window, bit 9 = earliest received bit
//   det      out  window equals COMMA_N or COMMA_P
// -----------------------------------------------------------------------------
module detector_coma
   import alineador_coma_pkg::*;
(
   input  logic       clk,
   input  logic       reset_L,
   input  logic       entrada,
   output logic [9:0] w,
   output logic       det
);

   // Nine history bits are enough: the tenth bit of the window is the live
   // input, which lets a comma be acted upon on the edge its last bit arrives.
   logic [8:0] sr_q;

   // NOTE: the shift register is reset so that the window after reset is a
   //       known all-zero pattern; otherwise stale bits could fake a comma.
   // NOTE: sequential state uses non-blocking assignments so every register
   //       samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         sr_q <= '0;
      end else begin
         sr_q <= {sr_q[7:0], entrada};
      end
   end

   assign w   = {sr_q, entrada};
   // An unknown input bit never equals a comma pattern, so X on the line is
   // simply treated as ordinary data by the FSM downstream.
   assign det = es_k285(w);

endmodule : detector_coma

// File: rtl/alineador_coma.sv
// -----------------------------------------------------------------------------
// alineador_coma
//
// Serial-to-word aligner for an 8b/10b link. It hunts for a K28.5 comma (either
// disparity), then requires COMAS_LOCK commas falling on the same 10-bit
// boundary before declaring lock. While locked it emits one aligned 10-bit
// symbol every 10 bit clocks with a single-cycle `valido` strobe. Commas seen
// off the locked boundary are counted; ERRORES_PERDIDA of them without an
// intervening on-boundary comma drop the lock and restart the hunt.
// Symbols are passed through undecoded; disparity and code checks are left to
// the decoder downstream.
//
// Parameters:
//   COMAS_LOCK       boundary-aligned commas needed to lock (2..7)
//   ERRORES_PERDIDA  off-boundary commas while locked that lose lock (1..7)
//
// Ports:
//   clk           in   bit clock, one serial bit per rising edge
//   reset_L       in   asynchronous active-low reset
//   entrada       in   serial data, first bit received is symbol bit 9
//   palabra       out  [9:0] aligned symbol, bit 9 = earliest received bit
//   valido        out  one-cycle strobe: `palabra` is new this cycle
//   es_coma       out  `palabra` is K28.5 (qualified by `valido`)
//   sincronizado  out  aligner is locked
//   perdidas      out  [7:0] saturating count of lock losses; only present
//                      when ALINEADOR_ESTADISTICAS_EN is defined
//
// Build option:
//   ALINEADOR_ESTADISTICAS_EN  adds the `perdidas` port and its counter.
// -----------------------------------------------------------------------------
module alineador_coma
   import alineador_coma_pkg::*;
#(
   parameter int unsigned COMAS_LOCK      = 3,
   parameter int unsigned ERRORES_PERDIDA = 2
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       entrada,
   output logic [9:0] palabra,
   output logic       valido,
   output logic       es_coma,
   output logic       sincronizado
`ifdef ALINEADOR_ESTADISTICAS_EN
   ,
   output logic [7:0] perdidas
`endif
);

   // Thresholds sized to the 3-bit counters they are compared against.
   localparam logic [2:0] LOCK_N = 3'(COMAS_LOCK);
   localparam logic [2:0] ERR_N  = 3'(ERRORES_PERDIDA);

   // ---------------------------------------------------------------------------
   // Window and comma detection
   // ---------------------------------------------------------------------------
   logic [9:0] w;
   logic       det;

   detector_coma u_detector (
      .clk     (clk),
      .reset_L (reset_L),
      .entrada (entrada),
      .w       (w),
      .det     (det)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   estado_e    estado_q,  estado_d;
   logic [3:0] fase_q,    fase_d;     // bit position inside the candidate symbol
   logic [2:0] n_comas_q, n_comas_d;  // aligned commas seen while verifying
   logic [2:0] errores_q, errores_d;  // off-boundary commas while locked
   logic [9:0] palabra_q, palabra_d;
   logic       valido_q,  valido_d;
   logic       es_coma_q, es_coma_d;
   logic       sinc_q,    sinc_d;

   // The window completes a symbol on the candidate boundary when the phase
   // counter sits on its last position.
   logic frontera;
   assign frontera = (fase_q == FASE_ULTIMA);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         estado_q  <= BUSCAR;
         fase_q    <= '0;
         n_comas_q <= '0;
         errores_q <= '0;
         palabra_q <= '0;
         valido_q  <= 1'b0;
         es_coma_q <= 1'b0;
         sinc_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         fase_q    <= fase_d;
         n_comas_q <= n_comas_d;
         errores_q <= errores_d;
         palabra_q <= palabra_d;
         valido_q  <= valido_d;
         es_coma_q <= es_coma_d;
         sinc_q    <= sinc_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path can leave one
      //       unassigned and infer a latch.
      estado_d  = estado_q;
      fase_d    = frontera ? 4'd0 : fase_q + 4'd1;
      n_comas_d = n_comas_q;
      errores_d = errores_q;
      palabra_d = palabra_q;
      valido_d  = 1'b0;
      es_coma_d = es_coma_q;
      sinc_d    = sinc_q;

      unique case (estado_q)
         BUSCAR: begin
            // The phase keeps running but is meaningless until a comma
            // anchors it; the comma's last bit becomes phase reference.
            if (det) begin
               fase_d    = 4'd0;
               n_comas_d = 3'd1;
               estado_d  = VERIFICAR;
            end
         end

         VERIFICAR: begin
            if (det && frontera) begin
               if (n_comas_q + 3'd1 == LOCK_N) begin
                  // The comma that completes the count is also the first
                  // word delivered, on this same edge.
                  estado_d  = SINCRONIZADO;
                  sinc_d    = 1'b1;
                  n_comas_d = n_comas_q + 3'd1;
                  errores_d = '0;
                  palabra_d = w;
                  valido_d  = 1'b1;
                  es_coma_d = 1'b1;
               end else begin
                  n_comas_d = n_comas_q + 3'd1;
               end
            end else if (det) begin
               // A comma on another phase is a better candidate than the
               // current one: re-anchor on it and start counting again.
               fase_d    = 4'd0;
               n_comas_d = 3'd1;
            end
            // Data on the boundary neither confirms nor refutes the candidate.
         end

         SINCRONIZADO: begin
            if (frontera) begin
               palabra_d = w;
               valido_d  = 1'b1;
               es_coma_d = det;
               if (det) begin
                  errores_d = '0;
               end
            end else if (det) begin
               if (errores_q + 3'd1 == ERR_N) begin
                  // Losing lock happens off-boundary, so no word is emitted.
                  estado_d  = BUSCAR;
                  sinc_d    = 1'b0;
                  n_comas_d = '0;
                  errores_d = '0;
               end else begin
                  errores_d = errores_q + 3'd1;
               end
            end
         end

         default: begin
            // Unused encoding: fall back to a clean hunt.
            estado_d  = BUSCAR;
            sinc_d    = 1'b0;
            n_comas_d = '0;
            errores_d = '0;
         end
      endcase
   end

   assign palabra      = palabra_q;
   assign valido       = valido_q;
   assign es_coma      = es_coma_q;
   assign sincronizado = sinc_q;

   // ---------------------------------------------------------------------------
   // Optional lock-loss statistics
   // ---------------------------------------------------------------------------
`ifdef ALINEADOR_ESTADISTICAS_EN
   logic [7:0] perdidas_q;
   logic       perdida;

   assign perdida = (estado_q == SINCRONIZADO) && (estado_d == BUSCAR);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         perdidas_q <= '0;
      end else if (perdida && (perdidas_q != 8'hFF)) begin
         // Saturates so a flapping link never wraps back to a small count.
         perdidas_q <= perdidas_q + 8'd1;
      end
   end

   assign perdidas = perdidas_q;
`endif

endmodule : alineador_coma

// File: tb/tb_alineador_coma.sv
// -----------------------------------------------------------------------------
// tb_alineador_coma
//
// Drives a serial bit stream into alineador_coma and checks every emitted
// word against a behavioural model that reasons in terms of absolute bit
// indices: a candidate boundary is "10*k bits after the anchoring comma".
// Expected words go into a queue; a monitor pops and compares on `valido`.
// -----------------------------------------------------------------------------
module tb_alineador_coma;

   localparam int CL = 3;
   localparam int EP = 2;

   localparam logic [9:0] K_N = 10'b0011111010;
   localparam logic [9:0] K_P = 10'b1100000101;
   localparam logic [9:0] D1  = 10'b1010010101;
   localparam logic [9:0] D2  = 10'b1111100000;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       entrada = 1'b0;
   logic [9:0] palabra;
   logic       valido;
   logic       es_coma;
   logic       sincronizado;
`ifdef ALINEADOR_ESTADISTICAS_EN
   logic [7:0] perdidas;
`endif

   always #5 clk = ~clk;

   alineador_coma #(
      .COMAS_LOCK      (CL),
      .ERRORES_PERDIDA (EP)
   ) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .entrada      (entrada),
      .palabra      (palabra),
      .valido       (valido),
      .es_coma      (es_coma),
      .sincronizado (sincronizado)
`ifdef ALINEADOR_ESTADISTICAS_EN
      ,
      .perdidas     (perdidas)
`endif
   );

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: absolute bit index, anchor index, modular arithmetic
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [9:0] w;
      logic       c;
   } sal_t;

   sal_t exp_q[$];

   logic [9:0] m_hist;
   int         m_t;
   int         m_ancla;
   int         m_modo;      // 0 hunting, 1 verifying, 2 locked
   int         m_comas;
   int         m_err;
   int         m_perdidas;
   logic       exp_sinc   = 1'b0;
   logic       exp_valido = 1'b0;
   logic       mon_en     = 1'b0;

   task automatic model_reset();
      m_hist     = '0;
      m_t        = 0;
      m_ancla    = 0;
      m_modo     = 0;
      m_comas    = 0;
      m_err      = 0;
      m_perdidas = 0;
      exp_sinc   = 1'b0;
      exp_valido = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic b);
      logic es_k;
      logic alineado;
      m_hist     = {m_hist[8:0], b};
      es_k       = (m_hist == K_N) || (m_hist == K_P);
      alineado   = (m_modo != 0) && (m_t != m_ancla) && (((m_t - m_ancla) % 10) == 0);
      exp_valido = 1'b0;
      if (m_modo == 0) begin
         if (es_k) begin
            m_ancla = m_t;
            m_comas = 1;
            m_modo  = 1;
         end
      end else if (m_modo == 1) begin
         if (es_k && alineado) begin
            m_comas++;
            if (m_comas == CL) begin
               m_modo = 2;
               m_err  = 0;
               exp_q.push_back('{w: m_hist, c: 1'b1});
               exp_valido = 1'b1;
            end
         end else if (es_k) begin
            m_ancla = m_t;
            m_comas = 1;
         end
      end else begin
         if (alineado) begin
            exp_q.push_back('{w: m_hist, c: es_k});
            exp_valido = 1'b1;
            if (es_k) m_err = 0;
         end else if (es_k) begin
            m_err++;
            if (m_err == EP) begin
               m_modo = 0;
               if (m_perdidas < 255) m_perdidas++;
            end
         end
      end
      m_t++;
      exp_sinc = (m_modo == 2);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: samples 1 time unit after each rising edge
   // ---------------------------------------------------------------------------
   initial begin
      sal_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            check("sincronizado", sincronizado, exp_sinc);
            check("valido", valido, exp_valido);
            if (valido && (exp_q.size() > 0)) begin
               e = exp_q.pop_front();
               check("palabra", palabra, e.w);
               check("es_coma", es_coma, e.c);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called at a falling edge, return at a falling edge)
   // ---------------------------------------------------------------------------
   task automatic send_bit(input logic b);
      entrada = b;
      model_step(b);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_sym(input logic [9:0] s);
      for (int i = 9; i >= 0; i--) send_bit(s[i]);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   // Asynchronous reset pulse, with an output check before the next edge.
   task automatic pulso_reset();
      mon_en = 1'b0;
      #2 reset_L = 1'b0;
      #1;
      check("rst_palabra", palabra, 10'd0);
      check("rst_valido", valido, 1'b0);
      check("rst_es_coma", es_coma, 1'b0);
      check("rst_sincronizado", sincronizado, 1'b0);
`ifdef ALINEADOR_ESTADISTICAS_EN
      check("rst_perdidas", perdidas, 8'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      model_reset();
      reset_L = 1'b1;
      mon_en  = 1'b1;
   endtask

   // Lock from hunting with three aligned commas, then slip and lose lock.
   task automatic lock_y_perdida(input string tag);
      send_sym(K_N);
      send_sym(K_P);
      send_sym(K_N);
      check({tag, "_lock"}, sincronizado, 1'b1);
      send_zeros(3);
      send_sym(K_N);
      check({tag, "_err1"}, sincronizado, 1'b1);
      send_sym(K_P);
      check({tag, "_perdida"}, sincronizado, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int   r;
      logic [9:0] s;

      model_reset();
      @(negedge clk);
      pulso_reset();

      // Idle line: never locks, never strobes.
      send_zeros(40);
      check("idle_sinc", sincronizado, 1'b0);

      // Lock on the fifth symbol of N, D, P, D, N.
      send_sym(K_N);
      send_sym(D1);
      send_sym(K_P);
      send_sym(D2);
      check("pre_lock_sinc", sincronizado, 1'b0);
      send_sym(K_N);
      check("lock_sinc", sincronizado, 1'b1);
      check("lock_valido", valido, 1'b1);
      check("lock_palabra", palabra, K_N);
      check("lock_es_coma", es_coma, 1'b1);
      send_sym(D1);
      check("next_palabra", palabra, D1);
      check("next_es_coma", es_coma, 1'b0);
      send_sym(D2);
      send_sym(K_P);
      check("locked_coma", palabra, K_P);

      // 3-bit slip: first off-boundary comma tolerated, second drops lock,
      // then three commas on the new phase relock.
      send_zeros(3);
      send_sym(K_N);
      check("slip_err1_sinc", sincronizado, 1'b1);
      send_sym(K_P);
      check("slip_perdida", sincronizado, 1'b0);
      send_sym(K_N);
      send_sym(K_P);
      check("relock_pre", sincronizado, 1'b0);
      send_sym(K_N);
      check("relock_sinc", sincronizado, 1'b1);
      check("relock_palabra", palabra, K_N);

      // Asynchronous reset four bits into a symbol while locked.
      send_sym(D1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      check("pre_reset_sinc", sincronizado, 1'b1);
      pulso_reset();

      // Fresh start: comma at offset 4 during verification restarts the count.
      send_zeros(40);
      send_sym(K_N);
      send_sym(D1);
      send_zeros(4);
      send_sym(K_P);
      send_sym(D2);
      send_sym(K_N);
      check("ofs4_pre", sincronizado, 1'b0);
      send_sym(D1);
      send_sym(K_P);
      check("ofs4_lock", sincronizado, 1'b1);
      check("ofs4_palabra", palabra, K_P);

      // Three lock losses from a clean start.
      pulso_reset();
      send_zeros(20);
      lock_y_perdida("p1");
      lock_y_perdida("p2");
      lock_y_perdida("p3");
`ifdef ALINEADOR_ESTADISTICAS_EN
      check("perdidas_3", perdidas, 8'd3);
`endif

      // Randomised traffic: commas, arbitrary data and occasional slips.
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            send_sym(($urandom_range(0, 1) == 0) ? K_N : K_P);
         end else if (r < 9) begin
            s = 10'($urandom);
            send_sym(s);
         end else begin
            r = $urandom_range(1, 9);
            for (int j = 0; j < r; j++) send_bit(1'($urandom));
         end
      end
      send_zeros(12);

`ifdef ALINEADOR_ESTADISTICAS_EN
      check("perdidas_final", perdidas, 8'(m_perdidas));
`endif
      mon_en = 1'b0;
      check("cola_pendiente", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_alineador_coma
